// File: rtl/hv_unpermute_unbind.sv
// Decoder-side inverse of the HV ALU encode path: optional XOR unbind with a key,
// followed by a multi-cycle circular left rotation, with valid/ready handshakes on both sides.
module hv_unpermute_unbind #(
    parameter int HVDimension = 512,
    parameter int MaxShiftAmt = 128,
    parameter int ShiftWidth  = $clog2(HVDimension),
    parameter int StepWidth   = $clog2(MaxShiftAmt) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [HVDimension-1:0] hv_i,
    input  logic [HVDimension-1:0] key_i,
    input  logic [ShiftWidth-1:0]  shift_amt_i,
    input  logic                   unbind_en_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [HVDimension-1:0] hv_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [HVDimension-1:0] work;
    logic [ShiftWidth-1:0]  rem;
    logic [StepWidth-1:0]   step;
    logic [ShiftWidth-1:0]  rem_next;
    logic                   ready_q;
    logic                   valid_q;
    logic                   busy_q;

    // The upper half of {x,x} shifted left by s is exactly x rotated left by s.
    function automatic logic [HVDimension-1:0] rotl(input logic [HVDimension-1:0] x,
                                                    input logic [StepWidth-1:0]   s);
        logic [2*HVDimension-1:0] dbl;
        dbl = {x, x} << s;
        return dbl[2*HVDimension-1:HVDimension];
    endfunction

    // Compare one bit wider so MaxShiftAmt == HVDimension still works.
    always_comb begin
        step = '0;
        if ({1'b0, rem} > (ShiftWidth+1)'(MaxShiftAmt)) begin
            step = StepWidth'(MaxShiftAmt);
        end else begin
            step = StepWidth'(rem);
        end
        rem_next = rem - ShiftWidth'(step);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            work    <= '0;
            rem     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        work    <= unbind_en_i ? (hv_i ^ key_i) : hv_i;
                        rem     <= shift_amt_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (shift_amt_i == '0) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state <= ROT;
                        end
                    end
                end
                ROT: begin
                    work <= rotl(work, step);
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hv_o    = work;
    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule
